conv_enc_stream: RTL

- Parametrised rate-1/2 feed-forward convolutional encoder with a valid/ready stream interface.
- Constraint length and both generator polynomials are parameters.
- When enabled, it appends K-1 zero tail bits after each frame so the trellis terminates in the all-zero state.
- It sits between the framing/scrambler stage and the interleaver/modulator and replaces the fixed K=3 encoder.

---
 rtl/conv_enc_stream.sv | 128 ++++++++++++
 1 files changed

// File: rtl/conv_enc_stream.sv
// Rate-1/2 feed-forward convolutional encoder (K, G0, G1 parametrised) with optional zero-tail flush.
// One-deep registered output: 1-cycle latency; input and tail both stall while the output slot is held.
module conv_enc_stream #(
    parameter int             K       = 3,
    parameter logic [K-1:0]   G0      = 3'b111,
    parameter logic [K-1:0]   G1      = 3'b101,
    parameter bit             TAIL_EN = 1'b1,
    parameter int             CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [K-2:0]     seed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_data,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] sym_count
);

    localparam int TW = $clog2(K);
    localparam logic [0:0] ST_DATA = 1'b0;
    localparam logic [0:0] ST_TAIL = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [K-2:0]     sr_q, sr_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic         slot_free;
    logic         accept;
    logic         tail_step;
    logic         enc_bit;
    logic [K-1:0] win;
    logic [1:0]   sym;

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = reset_n && (state_q == ST_DATA) && slot_free && !load;
    assign accept    = in_valid && in_ready;
    assign tail_step = (state_q == ST_TAIL) && slot_free;

    // Tail symbols encode a forced zero so the history drains to all-zero.
    assign enc_bit = (state_q == ST_TAIL) ? 1'b0 : in_data;
    assign win     = {enc_bit, sr_q};
    assign sym     = {^(win & G1), ^(win & G0)};

    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        sr_d        = sr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            sr_d        = {in_data, sr_q[K-2:1]};
            out_valid_d = 1'b1;
            out_data_d  = sym;
            out_last_d  = in_last && !TAIL_EN;
            if (in_last && TAIL_EN) begin
                state_d = ST_TAIL;
                tcnt_d  = TW'(K - 1);
            end
        end else if (tail_step) begin
            sr_d        = {1'b0, sr_q[K-2:1]};
            out_valid_d = 1'b1;
            out_data_d  = sym;
            out_last_d  = (tcnt_q == TW'(1));
            tcnt_d      = tcnt_q - TW'(1);
            if (tcnt_q == TW'(1)) begin
                state_d = ST_DATA;
            end
        end else if (load && (state_q == ST_DATA)) begin
            sr_d = seed;
        end
    end

    // Frame counter restarts on the handshake of the frame's closing symbol.
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid_q && out_ready) begin
            if (out_last_q) begin
                cnt_d = '0;
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_DATA;
            tcnt_q      <= '0;
            sr_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            sr_q        <= sr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign sym_count = cnt_q;
    assign busy      = (state_q == ST_TAIL) || out_valid_q;

endmodule
